// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its result buffer.
// Pure declarations: no logic, no latency, no flow control.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               exc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch results; head is read straight from storage (0-cycle read).
// Push is refused only when full with no pop; flush empties it and wins over push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head never exposes X, even when empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage sequencer: drives imem_addr, captures 1-cycle read data, buffers results for decode.
// First result 2 cycles after reset/redirect; issue is credit-gated so the buffer never overflows.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  input  logic        imem_exception,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_exc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;

  fetch_state_t       state;
  fetch_state_t       state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               inflight;

  logic               deq;
  logic               issue;
  logic               enq;
  logic               credit_ok;
  logic [OW-1:0]      occupancy;
  logic [OW-1:0]      limit;

  fetch_entry_t       head;
  fetch_entry_t       push_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  assign imem_addr = pc;
  assign deq       = out_valid & out_ready;

  // Buffered + in-flight entries must fit once this cycle's dequeue is accounted for.
  assign occupancy = OW'(fifo_count) + OW'(inflight);
  assign limit     = OW'(FIFO_DEPTH) + OW'(deq);
  assign credit_ok = (occupancy < limit) & ~(fifo_full & ~deq);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    enq       = 1'b0;
    if (redirect_valid) begin
      state_nxt = FETCH;
    end else if (state == FETCH) begin
      issue = credit_ok;
      enq   = inflight;
      if (inflight && imem_exception) begin
        state_nxt = HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (issue) begin
        pc          <= pc + PC_STEP;
        inflight_pc <= pc;
      end
    end
  end

  assign push_data.pc    = inflight_pc;
  assign push_data.instr = imem_dout;
  assign push_data.exc   = imem_exception;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (enq),
    .push_data (push_data),
    .pop       (deq),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = ~fifo_empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign out_exc   = head.exc;

endmodule
